mips32_prog_loader: RTL and testbench
=====================================

MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the instruction/data memory.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first word address written.
REQ-003 SHALL have parameter MAX_WORDS, default 64, maximum program length in words.
REQ-004 SHALL have port clk1  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port abort  input  1  cancel the load in progress.
REQ-008 SHALL have port in_valid  input  1  program word valid.
REQ-009 SHALL have port in_data  input  32  program word.
REQ-010 SHALL have port in_last  input  1  marks the final word of the program.
REQ-011 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-012 SHALL have port mem_we  output  1  memory write strobe.
REQ-013 SHALL have port mem_addr  output  ADDR_W  memory write word address.
REQ-014 SHALL have port mem_wdata  output  32  memory write data.
REQ-015 SHALL have port cpu_run  output  1  releases the processor (pc=0, halted=0, taken_branch=0 while low).
REQ-016 SHALL have port done  output  1  load completed successfully.
REQ-017 SHALL have port err  output  1  load failed (overflow or missing HLT).
REQ-018 SHALL have port word_count  output  ADDR_W  number of words accepted in the current or last load.
REQ-019 SHALL have port checksum  output  32  mod-2^32 sum of the accepted words.

Function
REQ-020 SHALL implement the states IDLE, LOAD, RUN and ERROR.
REQ-021 IDLE: in_ready=0; start=1 -> LOAD, clearing word_count, checksum and the halt_seen flag.
REQ-022 LOAD: in_ready=1; a beat is accepted when in_valid and in_ready are both high.
REQ-023 Each accepted beat SHALL produce, exactly one cycle later, mem_we=1, mem_addr=BASE_ADDR+word_count(pre-increment), mem_wdata=in_data.
REQ-024 mem_we SHALL be 0 in every cycle with no write pending.
REQ-025 Each accepted beat SHALL increment word_count by 1 and add in_data to checksum, with the carry out of bit 31 discarded.
REQ-026 halt_seen SHALL set when an accepted word has in_data[31:26]==6'b111111 (HLT, e.g. 0xfc000000).
REQ-027 Accepted beat with in_last=1 and halt_seen (including the current word) -> RUN; in_ready SHALL be 0 from the next cycle.
REQ-028 Accepted beat with in_last=1 and no HLT seen -> ERROR.
REQ-029 Accepted beat with in_last=0 when word_count==MAX_WORDS-1 -> ERROR (overflow); its write SHALL still occur.
REQ-030 A last word landing exactly on word MAX_WORDS-1 with in_last=1 is legal and SHALL NOT be treated as overflow.
REQ-031 abort=1 in LOAD -> IDLE next cycle; an accepted beat in the same cycle SHALL be discarded (no write, no count); abort has priority.
REQ-032 RUN: cpu_run=1, done=1; start and in_* SHALL be ignored; the state is left only by reset.
REQ-033 ERROR: err=1, cpu_run=0; start -> LOAD (retry, counters cleared).
REQ-034 start SHALL be ignored in LOAD.
REQ-035 The write pending from the final beat SHALL complete in the first cycle of RUN or ERROR.
REQ-036 cpu_run SHALL never be high before the final write has been issued.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, done=0, err=0, word_count=0, checksum=0, halt_seen=0, cancelling any pending write.
REQ-038 Reset mid-LOAD SHALL discard the partial load; a new start SHALL be required after reset is released.

Verification
REQ-039 Load 21 words (0x28050064 ... 0xfc000000, in_last on word 20), in_valid held high -> 21 writes to addresses 0..20 each one cycle after acceptance; word_count=21; done=1; cpu_run=1; checksum equals the mod-2^32 sum of the words.
REQ-040 Same program with in_valid toggling every other cycle -> identical memory contents and checksum, with no duplicate or skipped address.
REQ-041 3 words with in_last on 0x00202000 and no HLT -> ERROR, err=1, cpu_run=0; start then retries with word_count cleared to 0.
REQ-042 MAX_WORDS=4, 5 words supplied -> 4 writes then ERROR; a 4-word program ending in HLT with in_last -> RUN.
REQ-043 abort on the same cycle as beat 5 -> no write of beat 5, state IDLE; rst_n pulsed mid-load -> all outputs 0 asynchronously, before the next clk1 edge.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// Program loader for a MIPS32 core: streams program words into instruction
// memory, tracks length/checksum/HLT presence, then releases the CPU.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready are
// both high and abort is low; in_ready depends only on the loader state, never
// on in_valid, and the source holds in_data/in_last stable until accepted.
module mips32_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count,
  output logic [31:0]       checksum,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [5:0]        HLT_OP   = 6'b111111;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   word_count_q, word_count_d;
  logic [31:0]         checksum_q, checksum_d;
  logic                halt_seen_q, halt_seen_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                in_ready_q, in_ready_d;
  logic                cpu_run_q, cpu_run_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                halt_now;

  // Next-state, counters and the one-cycle-delayed write for each accepted beat.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    halt_seen_d  = halt_seen_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    halt_now     = halt_seen_q;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d      = ST_LOAD;
          word_count_d = '0;
          checksum_d   = '0;
          halt_seen_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        // abort wins over a beat presented in the same cycle
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          halt_now     = halt_seen_q | (in_data[31:26] == HLT_OP);
          mem_we_d     = 1'b1;
          mem_addr_d   = BASE_A + word_count_q;
          mem_wdata_d  = in_data;
          word_count_d = word_count_q + ONE;
          checksum_d   = checksum_q + in_data;
          halt_seen_d  = halt_now;
          if (in_last) begin
            state_d = halt_now ? ST_RUN : ST_ERROR;
          end else if (word_count_q == LAST_IDX) begin
            // the final slot was filled but the program claims to continue
            state_d = ST_ERROR;
          end
        end
      end
      default: begin
        // ST_RUN is terminal until reset
      end
    endcase

    // status outputs are registered copies of the next state decode, so
    // cpu_run rises in the same cycle the final write is presented
    in_ready_d = (state_d == ST_LOAD);
    cpu_run_d  = (state_d == ST_RUN);
    done_d     = (state_d == ST_RUN);
    err_d      = (state_d == ST_ERROR);
  end

  // State and output registers; reset clears everything including a pending write.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      checksum_q   <= '0;
      halt_seen_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      in_ready_q   <= 1'b0;
      cpu_run_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      halt_seen_q  <= halt_seen_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      in_ready_q   <= in_ready_d;
      cpu_run_q    <= cpu_run_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;
  assign checksum   = checksum_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: a per-cycle vector table for the basic state
// walk, then program loads scoreboarded against an expected write queue.
module tb_mips32_prog_loader;

  localparam int AW = 10;
  localparam int W  = AW + 32;
  localparam int B_BASE = 16;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  logic start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [31:0] in_data = 32'h0;

  logic          a_in_ready, a_mem_we, a_cpu_run, a_done, a_err;
  logic [AW-1:0] a_mem_addr, a_word_count;
  logic [31:0]   a_mem_wdata, a_checksum;
  logic [1:0]    a_state;
  logic          b_in_ready, b_mem_we, b_cpu_run, b_done, b_err;
  logic [AW-1:0] b_mem_addr, b_word_count;
  logic [31:0]   b_mem_wdata, b_checksum;
  logic [1:0]    b_state;

  mips32_prog_loader u_a (
    .clk1(clk1), .rst_n(rst_n), .start(start_a), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(a_in_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .cpu_run(a_cpu_run), .done(a_done), .err(a_err),
    .word_count(a_word_count), .checksum(a_checksum), .state_dbg(a_state)
  );

  mips32_prog_loader #(.MAX_WORDS(4), .BASE_ADDR(B_BASE)) u_b (
    .clk1(clk1), .rst_n(rst_n), .start(start_b), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .cpu_run(b_cpu_run), .done(b_done), .err(b_err),
    .word_count(b_word_count), .checksum(b_checksum), .state_dbg(b_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  bit mon_q_en = 1'b0;
  logic acc_a, acc_b;
  int wr_a = 0, wr_b = 0;
  logic [31:0] prog [0:20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // a beat is accepted on an edge with in_valid && in_ready && !abort
  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      acc_a <= 1'b0;
      acc_b <= 1'b0;
    end else begin
      acc_a <= in_valid && a_in_ready && !abort;
      acc_b <= in_valid && b_in_ready && !abort;
    end
  end

  always @(negedge clk1) begin
    logic [W-1:0] e;
    if (rst_n) begin
      chk("a_we_latency", a_mem_we, acc_a);
      chk("b_we_latency", b_mem_we, acc_b);
      if (a_mem_we) begin
        wr_a++;
        if (mon_q_en) begin
          if (exp_a.size() == 0) chk("a_unexpected_write", a_mem_addr, 32'hffff_ffff);
          else begin
            e = exp_a.pop_front();
            chk("a_wr_addr", a_mem_addr, e[W-1:32]);
            chk("a_wr_data", a_mem_wdata, e[31:0]);
          end
        end
      end
      if (b_mem_we) begin
        wr_b++;
        if (mon_q_en) begin
          if (exp_b.size() == 0) chk("b_unexpected_write", b_mem_addr, 32'hffff_ffff);
          else begin
            e = exp_b.pop_front();
            chk("b_wr_addr", b_mem_addr, e[W-1:32]);
            chk("b_wr_data", b_mem_wdata, e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk1);
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;
    #2 rst_n = 1'b1;
    exp_a.delete();
    exp_b.delete();
    wr_a = 0;
    wr_b = 0;
  endtask

  task automatic pulse_start(input bit sel_b);
    @(negedge clk1);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drive_prog(input bit sel_b, input int n, input bit use_last, input bit toggle);
    int i = 0;
    int cyc = 0;
    bit gap = 1'b0;
    bit broke = 1'b0;
    logic rdy;
    logic [AW-1:0] addr;
    while (i < n && cyc < 300 && !broke) begin
      @(negedge clk1);
      rdy = sel_b ? b_in_ready : a_in_ready;
      if (!rdy && i > 0) begin
        broke = 1'b1;
      end else begin
        if (toggle && gap) begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = prog[i];
          in_last  = use_last && (i == n - 1);
          if (rdy) begin
            addr = AW'((sel_b ? B_BASE : 0) + i);
            if (sel_b) exp_b.push_back({addr, prog[i]});
            else       exp_a.push_back({addr, prog[i]});
            i++;
          end
        end
        gap = toggle && !gap;
        cyc++;
      end
    end
    if (!broke) @(negedge clk1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("drive_timeout", (cyc < 300), 1);
  endtask

  task automatic chk_a(input string tag, input logic [AW-1:0] wc, input logic [31:0] cs,
                       input logic rdy, input logic dn, input logic er, input logic run);
    chk({tag, "_wc"}, a_word_count, wc);
    chk({tag, "_cs"}, a_checksum, cs);
    chk({tag, "_ready"}, a_in_ready, rdy);
    chk({tag, "_done"}, a_done, dn);
    chk({tag, "_err"}, a_err, er);
    chk({tag, "_run"}, a_cpu_run, run);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start, valid, last, abrt;
    logic [31:0] data;
    logic        e_ready, e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
    logic [9:0]  e_wc;
    logic [31:0] e_cs;
    logic        e_done, e_err, e_run;
  } vec_t;

  vec_t vecs[12];

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] sum;

    prog[0] = 32'h2805_0064;
    for (int i = 1; i < 20; i++) prog[i] = 32'h2000_0000 | (i * 32'h0001_0003);
    prog[20] = 32'hfc00_0000;

    // reset state, sampled while rst_n is still low
    #3;
    chk("rst_a_we", a_mem_we, 0);
    chk("rst_a_addr", a_mem_addr, 0);
    chk("rst_a_wdata", a_mem_wdata, 0);
    chk_a("rst_a", 0, 0, 0, 0, 0, 0);
    chk("rst_a_state", a_state, 0);
    chk("rst_b_ready", b_in_ready, 0);
    chk("rst_b_wc", b_word_count, 0);
    @(negedge clk1);
    #2 rst_n = 1'b1;

    // start/valid/last/abort/data -> ready/we/addr/wdata/wc/cs/done/err/run after the edge
    vecs[0]  = '{1, 0, 0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         10'd0, 32'h0,         0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 32'h1111_1111, 1, 1, 10'd0, 32'h1111_1111, 10'd1, 32'h1111_1111, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         10'd1, 32'h1111_1111, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 32'h0020_2000, 1, 1, 10'd1, 32'h0020_2000, 10'd2, 32'h1131_3111, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         10'd2, 32'h1131_3111, 0, 0, 0};
    vecs[5]  = '{0, 1, 1, 0, 32'h0020_2000, 0, 1, 10'd2, 32'h0020_2000, 10'd3, 32'h1151_5111, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 32'h0,         0, 0, 10'd0, 32'h0,         10'd3, 32'h1151_5111, 0, 1, 0};
    vecs[7]  = '{1, 0, 0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         10'd0, 32'h0,         0, 0, 0};
    vecs[8]  = '{0, 1, 0, 1, 32'hfc00_0000, 0, 0, 10'd0, 32'h0,         10'd0, 32'h0,         0, 0, 0};
    vecs[9]  = '{1, 0, 0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         10'd0, 32'h0,         0, 0, 0};
    vecs[10] = '{0, 1, 1, 0, 32'hfc00_0000, 0, 1, 10'd0, 32'hfc00_0000, 10'd1, 32'hfc00_0000, 1, 0, 1};
    vecs[11] = '{1, 1, 1, 0, 32'h1234_5678, 0, 0, 10'd0, 32'h0,         10'd1, 32'hfc00_0000, 1, 0, 1};

    @(negedge clk1);
    for (int i = 0; i < 12; i++) begin
      start_a  = vecs[i].start;
      in_valid = vecs[i].valid;
      in_last  = vecs[i].last;
      abort    = vecs[i].abrt;
      in_data  = vecs[i].data;
      @(negedge clk1);
      chk($sformatf("vec%0d_ready", i), a_in_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_we", i), a_mem_we, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_addr", i), a_mem_addr, vecs[i].e_addr);
        chk($sformatf("vec%0d_wdata", i), a_mem_wdata, vecs[i].e_wdata);
      end
      chk($sformatf("vec%0d_wc", i), a_word_count, vecs[i].e_wc);
      chk($sformatf("vec%0d_cs", i), a_checksum, vecs[i].e_cs);
      chk($sformatf("vec%0d_done", i), a_done, vecs[i].e_done);
      chk($sformatf("vec%0d_err", i), a_err, vecs[i].e_err);
      chk($sformatf("vec%0d_run", i), a_cpu_run, vecs[i].e_run);
    end
    start_a = 1'b0; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0;
    mon_q_en = 1'b1;

    sum = 32'h0;
    for (int i = 0; i < 21; i++) sum = sum + prog[i];

    // 21-word program, in_valid held high
    do_reset();
    pulse_start(1'b0);
    drive_prog(1'b0, 21, 1'b1, 1'b0);
    repeat (2) @(negedge clk1);
    chk("full_queue_empty", exp_a.size(), 0);
    chk("full_writes", wr_a, 21);
    chk_a("full", 21, sum, 0, 1, 0, 1);

    // same program with in_valid toggling every other cycle
    do_reset();
    pulse_start(1'b0);
    drive_prog(1'b0, 21, 1'b1, 1'b1);
    repeat (2) @(negedge clk1);
    chk("tog_queue_empty", exp_a.size(), 0);
    chk("tog_writes", wr_a, 21);
    chk_a("tog", 21, sum, 0, 1, 0, 1);

    // 3 words ending on 0x00202000 without HLT, then retry
    prog[2] = 32'h0020_2000;
    do_reset();
    pulse_start(1'b0);
    drive_prog(1'b0, 3, 1'b1, 1'b0);
    @(negedge clk1);
    chk_a("nohlt", 3, prog[0] + prog[1] + prog[2], 0, 0, 1, 0);
    chk("nohlt_state", a_state, 3);
    pulse_start(1'b0);
    chk_a("retry", 0, 0, 1, 0, 0, 0);
    @(negedge clk1);
    abort = 1'b1;
    @(negedge clk1);
    abort = 1'b0;
    chk("retry_abort_state", a_state, 0);

    // MAX_WORDS=4: five words offered, four written, then overflow
    do_reset();
    pulse_start(1'b1);
    drive_prog(1'b1, 5, 1'b0, 1'b0);
    repeat (2) @(negedge clk1);
    chk("ovf_writes", wr_b, 4);
    chk("ovf_queue_empty", exp_b.size(), 0);
    chk("ovf_err", b_err, 1);
    chk("ovf_run", b_cpu_run, 0);
    chk("ovf_wc", b_word_count, 4);
    // exactly four words ending in HLT with in_last is legal
    prog[3] = 32'hfc00_0000;
    pulse_start(1'b1);
    drive_prog(1'b1, 4, 1'b1, 1'b0);
    repeat (2) @(negedge clk1);
    chk("fit_queue_empty", exp_b.size(), 0);
    chk("fit_done", b_done, 1);
    chk("fit_run", b_cpu_run, 1);
    chk("fit_err", b_err, 0);
    chk("fit_wc", b_word_count, 4);
    chk("fit_cs", b_checksum, prog[0] + prog[1] + prog[2] + prog[3]);

    // abort on the same cycle as beat 5
    do_reset();
    pulse_start(1'b0);
    drive_prog(1'b0, 4, 1'b0, 1'b0);
    @(negedge clk1);
    in_valid = 1'b1; in_data = prog[4]; abort = 1'b1;
    @(negedge clk1);
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_state", a_state, 0);
    chk("abort_ready", a_in_ready, 0);
    chk("abort_wc", a_word_count, 4);
    chk("abort_writes", wr_a, 4);
    chk("abort_queue_empty", exp_a.size(), 0);

    // asynchronous reset with a write pending
    do_reset();
    pulse_start(1'b0);
    @(negedge clk1);
    in_valid = 1'b1; in_data = prog[0]; in_last = 1'b0;
    @(posedge clk1);
    #2;
    chk("prerst_we", a_mem_we, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_we", a_mem_we, 0);
    chk("arst_addr", a_mem_addr, 0);
    chk("arst_wdata", a_mem_wdata, 0);
    chk_a("arst", 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk1);
    chk("post_rst_state", a_state, 0);
    chk("post_rst_ready", a_in_ready, 0);
    chk("post_rst_wc", a_word_count, 0);

    chk("end_queue_a", exp_a.size(), 0);
    chk("end_queue_b", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
